// File: rtl/control_seq_pkg.sv
// rtl/control_seq_pkg.sv - shared state encoding and fixed field codes for the nic8 control sequencer
package control_seq_pkg;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        HALT,
        FAULT
    } state_t;

    localparam int DEST_PC  = 1;
    localparam int DEST_MEM = 5;
    localparam int SRC_IMM  = 0;
    localparam int SRC_ZERO = 1;
    localparam int SRC_RAM  = 5;
    localparam int SRC_ALU  = 6;
    localparam int OP_HALT  = 0;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational IR field split, one-hot expansion and jump evaluation
module control_decode
    import control_seq_pkg::*;
#(
    parameter int DEST_W = 3,
    parameter int SRC_W  = 3
) (
    input  logic [DEST_W+SRC_W+1:0] ir,
    input  logic                    a_is_zero,
    input  logic                    carry_flag,
    output logic [DEST_W-1:0]       dest,
    output logic [SRC_W-1:0]        src,
    output logic                    jz,
    output logic [2**DEST_W-1:0]    dest_onehot,
    output logic [2**SRC_W-1:0]     src_onehot,
    output logic                    is_mem,
    output logic                    is_halt,
    output logic                    is_nop,
    output logic                    jump_taken
);

    localparam int IR_W = DEST_W + SRC_W + 2;
    localparam int DN   = 2**DEST_W;
    localparam int SN   = 2**SRC_W;

    logic jc;

    assign {jc, dest, jz, src} = ir;

    assign dest_onehot = DN'(1) << dest;
    assign src_onehot  = SN'(1) << src;

    assign is_mem  = (src == SRC_W'(SRC_RAM)) || (dest == DEST_W'(DEST_MEM));
    assign is_halt = (ir == IR_W'(OP_HALT));
    assign is_nop  = (dest == '0);

    // Neither condition bit set means an unconditional jump.
    assign jump_taken = (jz & a_is_zero) | (jc & carry_flag) | (~jz & ~jc);

endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - nic8 FETCH/EXEC control sequencer; CONTROL_SEQ_RETIRE_EN enables the retired counter
module control_seq
    import control_seq_pkg::*;
#(
    parameter int DEST_W       = 3,
    parameter int SRC_W        = 3,
    parameter int MEM_WAIT_MAX = 15,
    parameter int RETIRE_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DEST_W+SRC_W+1:0] ir_bus,
    input  logic                    a_is_zero,
    input  logic                    carry_in,
    input  logic                    mem_ready,
    output logic                    ir_load,
    output logic                    pc_inc,
    output logic [2**DEST_W-1:0]    dest_we,
    output logic [2**SRC_W-1:0]     src_oe,
    output logic                    alu_sub,
    output logic                    mem_req,
    output logic                    carry_flag,
    output logic                    halted,
    output logic                    fault,
    output logic [RETIRE_W-1:0]     retired
);

    localparam int IR_W   = DEST_W + SRC_W + 2;
    localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W+1)'(MEM_WAIT_MAX);

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q;
    logic                carry_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [WAIT_W:0]     wait_next;

    logic [DEST_W-1:0]   dest;
    logic [SRC_W-1:0]    src;
    logic                jz, is_mem, is_halt, is_nop, jump_taken;
    logic [2**DEST_W-1:0] dest_onehot;
    logic [2**SRC_W-1:0]  src_onehot;

    logic                 ir_load_c, pc_inc_c, alu_sub_c, mem_req_c, halted_c, fault_c, complete;
    logic [2**DEST_W-1:0] dest_we_c;
    logic [2**SRC_W-1:0]  src_oe_c;

    control_decode #(.DEST_W(DEST_W), .SRC_W(SRC_W)) u_decode (
        .ir          (ir_q),
        .a_is_zero   (a_is_zero),
        .carry_flag  (carry_q),
        .dest        (dest),
        .src         (src),
        .jz          (jz),
        .dest_onehot (dest_onehot),
        .src_onehot  (src_onehot),
        .is_mem      (is_mem),
        .is_halt     (is_halt),
        .is_nop      (is_nop),
        .jump_taken  (jump_taken)
    );

    assign wait_next = {1'b0, wait_q} + 1'b1;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ir_load_c = 1'b0;
        pc_inc_c  = 1'b0;
        alu_sub_c = 1'b0;
        mem_req_c = 1'b0;
        halted_c  = 1'b0;
        fault_c   = 1'b0;
        complete  = 1'b0;
        dest_we_c = '0;
        src_oe_c  = '0;
        case (state_q)
            FETCH: begin
                ir_load_c = 1'b1;
                pc_inc_c  = 1'b1;
                state_d   = EXEC;
            end
            EXEC: begin
                if (is_halt) begin
                    complete = 1'b1;
                    state_d  = HALT;
                end else begin
                    alu_sub_c = jz;
                    pc_inc_c  = (src == SRC_W'(SRC_IMM));
                    src_oe_c  = is_nop ? '0 : src_onehot;
                    if (is_mem) begin
                        mem_req_c = 1'b1;
                        wait_d    = '0;
                        complete  = mem_ready;
                        state_d   = mem_ready ? FETCH : MEM;
                    end else begin
                        complete = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            MEM: begin
                alu_sub_c = jz;
                mem_req_c = 1'b1;
                src_oe_c  = is_nop ? '0 : src_onehot;
                // A ready on the final wait cycle still wins over the timeout.
                if (mem_ready) begin
                    complete = 1'b1;
                    state_d  = FETCH;
                end else if (MEM_WAIT_MAX != 0 && wait_next == WAIT_LIMIT) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_next[WAIT_W-1:0];
                end
            end
            HALT:    halted_c = 1'b1;
            FAULT:   fault_c  = 1'b1;
            default: state_d  = FETCH;
        endcase
        if (complete && !is_nop && !(dest == DEST_W'(DEST_PC) && !jump_taken))
            dest_we_c = dest_onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            carry_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (ir_load_c)
                ir_q <= ir_bus;
            if (complete && !is_nop && src == SRC_W'(SRC_ALU))
                carry_q <= carry_in;
        end
    end

    assign ir_load    = ~reset & ir_load_c;
    assign pc_inc     = ~reset & pc_inc_c;
    assign alu_sub    = ~reset & alu_sub_c;
    assign mem_req    = ~reset & mem_req_c;
    assign carry_flag = ~reset & carry_q;
    assign halted     = ~reset & halted_c;
    assign fault      = ~reset & fault_c;
    assign dest_we    = reset ? '0 : dest_we_c;
    assign src_oe     = reset ? '0 : src_oe_c;

`ifdef CONTROL_SEQ_RETIRE_EN
    logic [RETIRE_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset)
            retired_q <= '0;
        else if (complete)
            retired_q <= retired_q + 1'b1;
    end

    assign retired = reset ? '0 : retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - scoreboard bench for control_seq (MEM_WAIT_MAX=4, RETIRE_W=2)
module tb_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir_bus = 8'h00;
    logic       a_is_zero = 1'b0;
    logic       carry_in = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_load, pc_inc, alu_sub, mem_req, carry_flag, halted, fault;
    logic [7:0] dest_we, src_oe;
    logic [1:0] retired;

    control_seq #(.DEST_W(3), .SRC_W(3), .MEM_WAIT_MAX(4), .RETIRE_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_bus     (ir_bus),
        .a_is_zero  (a_is_zero),
        .carry_in   (carry_in),
        .mem_ready  (mem_ready),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .dest_we    (dest_we),
        .src_oe     (src_oe),
        .alu_sub    (alu_sub),
        .mem_req    (mem_req),
        .carry_flag (carry_flag),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ir;
        logic        az, ci, mr, rs;
        logic [24:0] exp;
    } entry_t;

    entry_t     sbq[$];
    logic [1:0] ret_model = 2'd0;
    logic       cf_model  = 1'b0;
    int         n_tests   = 0;
    int         n_fail    = 0;

    // {ir_load, pc_inc, dest_we, src_oe, alu_sub, mem_req, carry_flag, halted, fault, retired}
    logic [24:0] obs;
    assign obs = {ir_load, pc_inc, dest_we, src_oe, alu_sub, mem_req, carry_flag, halted, fault, retired};

    task automatic push(input logic [7:0] ir, input logic az, ci, mr, rs,
                        input logic il, pi, input logic [7:0] dw, so,
                        input logic as_, mq, h, f, done);
        entry_t     e;
        logic [1:0] rv;
`ifdef CONTROL_SEQ_RETIRE_EN
        rv = ret_model;
`else
        rv = 2'd0;
`endif
        e.ir = ir; e.az = az; e.ci = ci; e.mr = mr; e.rs = rs;
        e.exp = rs ? 25'd0 : {il, pi, dw, so, as_, mq, cf_model, h, f, rv};
        sbq.push_back(e);
        if (rs) begin
            ret_model = 2'd0;
            cf_model  = 1'b0;
        end else if (done) begin
            ret_model = ret_model + 2'd1;
        end
    endtask

    task automatic rst();
        push(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [7:0] ir);
        push(ir, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        entry_t e;
        rst(); rst();
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_move();
        entry_t e;
        fetch(8'h32);
        push(8'h32, 0, 0, 0, 0, 0, 0, 8'h08, 8'h04, 0, 0, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL move_b_a: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_jump();
        entry_t e;
        fetch(8'h18);
        push(8'h18, 1, 0, 0, 0, 0, 1, 8'h02, 8'h01, 1, 0, 0, 0, 1);
        fetch(8'h18);
        push(8'h18, 0, 0, 0, 0, 0, 1, 8'h00, 8'h01, 1, 0, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL jump_zero: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_mem();
        entry_t e;
        fetch(8'h25);
        for (int i = 0; i < 3; i++)
            push(8'h25, 0, 0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 0, 0, 0);
        push(8'h25, 0, 0, 1, 0, 0, 0, 8'h04, 8'h20, 0, 1, 0, 0, 1);
        fetch(8'h25);
        push(8'h25, 0, 0, 1, 0, 0, 0, 8'h04, 8'h20, 0, 1, 0, 0, 1);
        fetch(8'h52);
        push(8'h52, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0, 0, 0);
        push(8'h52, 0, 0, 1, 0, 0, 0, 8'h20, 8'h04, 0, 1, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL ram_access: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_carry();
        entry_t e;
        fetch(8'h90);
        push(8'h90, 0, 0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0, 0, 1);
        fetch(8'h2E);
        push(8'h2E, 0, 1, 0, 0, 0, 0, 8'h04, 8'h40, 1, 0, 0, 0, 1);
        cf_model = 1'b1;
        fetch(8'h90);
        push(8'h90, 0, 0, 0, 0, 0, 1, 8'h02, 8'h01, 0, 0, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL carry_jump: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_timeout();
        entry_t e;
        rst();
        fetch(8'h25);
        for (int i = 0; i < 5; i++)
            push(8'h25, 0, 0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            push(8'h25, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0);
        rst();
        fetch(8'h32);
        push(8'h32, 0, 0, 0, 0, 0, 0, 8'h08, 8'h04, 0, 0, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL mem_timeout: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_halt();
        entry_t e;
        rst();
        fetch(8'h00);
        push(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            push(8'h00, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        rst();
        fetch(8'h08);
        push(8'h08, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 1);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL halt_nop: got %h want %h", obs, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        entry_t e;
        for (int i = 0; i < 5; i++) begin
            fetch(8'h32);
            push(8'h32, 0, 0, 0, 0, 0, 0, 8'h08, 8'h04, 0, 0, 0, 0, 1);
        end
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            ir_bus = e.ir; a_is_zero = e.az; carry_in = e.ci; mem_ready = e.mr; reset = e.rs;
            #1;
            n_tests++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL back_to_back: got %h want %h", obs, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_jump();
        test_mem();
        test_carry();
        test_timeout();
        test_halt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Multi-cycle control sequencer for the nic8 CPU. Replaces the purely combinational IR decode.
- Owns a FETCH/EXEC state machine, the RAM wait handshake with timeout, a latched carry flag, and a HALT state.
- Emits one-hot register write enables and one-hot bus output enables, plus PC, IR and ALU controls.
- Field widths are parametrised, so the register-file and bus-source counts can grow.

Parameters:
- DEST_W, 3, destination field width; dest_we width = 2**DEST_W
- SRC_W, 3, source field width; src_oe width = 2**SRC_W
- MEM_WAIT_MAX, 15, max cycles in MEM before fault; 0 = no timeout
- RETIRE_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ir_bus  in  IR_W (=DEST_W+SRC_W+2)  instruction byte from ROM, captured in FETCH
- a_is_zero  in  1  accumulator-zero status, sampled in EXEC
- carry_in  in  1  ALU carry-out
- mem_ready  in  1  RAM access complete this cycle
- ir_load  out  1  capture ir_bus into IR
- pc_inc  out  1  increment PC
- dest_we  out  2**DEST_W  one-hot destination write enable
- src_oe  out  2**SRC_W  one-hot bus source enable
- alu_sub  out  1  ALU subtract (IR bit SRC_W)
- mem_req  out  1  RAM access in progress
- carry_flag  out  1  latched carry
- halted  out  1  in HALT
- fault  out  1  sticky RAM timeout
- retired  out  RETIRE_W  retired-instruction count

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- IR layout, MSB to LSB: {jc, dest, jz, src}.
- Fixed codes:
  - Destinations: 0 reserved/NOP, 1 PC, 2 A, 3 B, 4 X, 5 RAM store, 6 Q, 7 Qhi.
  - Sources: 0 ROM immediate, 1 zero, 2 A, 3 B, 4 X, 5 RAM, 6 ALU, 7 S.
  - Codes above 7 are generic registers.
- Reset:
  - While reset is high, every output is 0 and retired is 0.
  - State goes to FETCH; carry_flag and fault clear.
  - Reset in any state, including MEM or FAULT, aborts on the next edge.
- FETCH:
  - Asserts ir_load=1 and pc_inc=1.
  - The IR register loads; next state is EXEC. One cycle.
- EXEC, with the IR decoded:
  - src_oe[src] is asserted, except for the HALT opcode and dest==0 (NOP).
  - pc_inc=1 when src==0 (immediate byte consumed).
  - alu_sub mirrors IR bit jz.
- dest==PC is a conditional jump:
  - Jump condition: (jz & a_is_zero) | (jc & carry_flag) | (~jz & ~jc).
  - dest_we[1] is asserted only if the condition is true.
- dest==0:
  - IR==0 (HALT opcode) → HALT state.
  - Any other dest==0 encoding is a NOP.
- Memory instructions (src==5 or dest==5):
  - mem_req=1 in EXEC and in every MEM cycle.
  - If mem_ready=1 in EXEC, the access completes in EXEC.
  - Otherwise next state is MEM; src_oe is held. dest_we is asserted only in the completing cycle (mem_ready=1).
- Non-memory instructions:
  - dest_we[dest] is asserted in EXEC; next state is FETCH.
  - Total latency: 2 cycles non-memory, 2+N memory.
- MEM:
  - A wait counter starts at 0 on entry and increments each MEM cycle without mem_ready.
  - mem_ready=1 → complete; next state FETCH.
  - Counter reaches MEM_WAIT_MAX (when nonzero) without mem_ready → FAULT.
  - On that cycle mem_ready has priority over timeout.
- Carry flag:
  - On the completing cycle, if src==6 and dest!=0, carry_flag ← carry_in.
  - Otherwise it holds.
- HALT and FAULT are terminal until reset; all strobes are 0.
  - halted=1 in HALT.
  - fault=1 in FAULT.
- Outputs are combinational from state and IR register.
  - Only state, IR, carry_flag, the wait counter and retired are registers.

Optional Feature:
- Macro: CONTROL_SEQ_RETIRE_EN.
- Defined:
  - retired increments by 1 on each instruction-completing cycle (EXEC or MEM completion, including NOP, not-taken jump and HALT entry).
  - It wraps modulo 2**RETIRE_W.
- Undefined: retired is tied to 0 and the counter logic is absent.

Decomposition:
- Package control_seq_pkg holds:
  - State enum: FETCH, EXEC, MEM, HALT, FAULT.
  - Constants DEST_PC=1, DEST_MEM=5, SRC_IMM=0, SRC_ZERO=1, SRC_RAM=5, SRC_ALU=6, OP_HALT=0.
- One sub-module, control_decode (combinational), produces:
  - Field split.
  - One-hot expansion.
  - is_mem and jump_taken.
- control_seq instantiates control_decode and owns all registers.

Test Plan:
- Reset, then ir_bus=0x32 (B←A): cycle 1 FETCH (ir_load=1, pc_inc=1); cycle 2 dest_we=0x08, src_oe=0x04; then back to FETCH.
- Jump-if-zero on 0x18:
  - a_is_zero=1 → dest_we=0x02, src_oe=0x01, pc_inc=1.
  - a_is_zero=0 → dest_we=0x00, pc_inc still 1.
- RAM load 0x25 with mem_ready low for 3 cycles:
  - mem_req=1 and src_oe=0x20 for 4 cycles.
  - dest_we=0x04 only in the 4th.
  - Then FETCH.
- Timeout: MEM_WAIT_MAX=4, mem_ready stuck 0:
  - fault=1 after 4 MEM cycles; stays 1.
  - Reset clears fault.
- Carry path: 0x2E with carry_in=1 → carry_flag=1, alu_sub=1; then 0x90 → dest_we=0x02 (taken).
- HALT 0x00 → halted=1, all strobes 0 indefinitely.
  - With CONTROL_SEQ_RETIRE_EN, retired counts every instruction including HALT and wraps at RETIRE_W=2.
